// File: rtl/serial_subtractor_32_if.sv
// Operand/result handshake bundle for serial_subtractor_32.
// The ovf wire exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, diff, borrow, zero
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, diff, borrow, zero
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor_32.sv
// Multi-cycle LSB-first subtractor: diff = x - y, BITS_PER_CYCLE bits per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_32 #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_32_if.slave bus
);
  localparam int NCYC  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          xs_q, xs_d;
  logic [WIDTH-1:0]          ys_q, ys_d;
  logic [WIDTH-1:0]          res_q, res_d;
  logic                      bint_q, bint_d;
  logic [WIDTH-1:0]          diff_q, diff_d;
  logic                      borrow_q, borrow_d;
  logic                      zero_q, zero_d;
`ifdef SERIAL_SUB_OVF_EN
  logic                      xmsb_q, xmsb_d;
  logic                      ymsb_q, ymsb_d;
  logic                      ovf_q, ovf_d;
`endif

  logic [BITS_PER_CYCLE-1:0] slice_d;
  logic                      slice_bo;
  logic                      a_bit, b_bit, bi, bo;
  logic [WIDTH-1:0]          res_next;

  // Full-subtractor ripple across the low BITS_PER_CYCLE bits of the operand shifters
  always_comb begin
    slice_d = '0;
    a_bit   = 1'b0;
    b_bit   = 1'b0;
    bo      = 1'b0;
    bi      = bint_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      a_bit      = xs_q[i];
      b_bit      = ys_q[i];
      slice_d[i] = a_bit ^ b_bit ^ bi;
      bo         = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bi);
      bi         = bo;
    end
    slice_bo = bi;
    // New slice enters at the MSB end so the LSB slice lands at bit 0 after NCYC shifts
    res_next = (res_q >> BITS_PER_CYCLE) | (WIDTH'(slice_d) << (WIDTH - BITS_PER_CYCLE));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    res_d    = res_q;
    bint_d   = bint_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    xmsb_d   = xmsb_q;
    ymsb_d   = ymsb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          xs_d    = bus.x;
          ys_d    = bus.y;
          bint_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
          xmsb_d  = bus.x[WIDTH-1];
          ymsb_d  = bus.y[WIDTH-1];
`endif
        end
      end
      RUN: begin
        xs_d   = xs_q >> BITS_PER_CYCLE;
        ys_d   = ys_q >> BITS_PER_CYCLE;
        res_d  = res_next;
        bint_d = slice_bo;
        cnt_d  = cnt_q + 1'b1;
        // Outputs update only when the whole result is ready, so they stay stable while running
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          diff_d   = res_next;
          borrow_d = slice_bo;
          zero_d   = (res_next == '0);
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (xmsb_q != ymsb_q) & (res_next[WIDTH-1] != xmsb_q);
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      xs_q     <= '0;
      ys_q     <= '0;
      res_q    <= '0;
      bint_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      xmsb_q   <= 1'b0;
      ymsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      res_q    <= res_d;
      bint_q   <= bint_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
      xmsb_q   <= xmsb_d;
      ymsb_q   <= ymsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.zero      = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Directed + randomized bench for serial_subtractor_32 (BPC=1 and BPC=4 instances).
// Checks ovf only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor_32;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_32_if #(.WIDTH(32)) bus_a ();
  serial_subtractor_32_if #(.WIDTH(32)) bus_b ();

  serial_subtractor_32 #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  serial_subtractor_32 #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } obs_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic rdy);
    if (!sel) begin
      bus_a.in_valid = v; bus_a.x = x; bus_a.y = y; bus_a.out_ready = rdy;
    end else begin
      bus_b.in_valid = v; bus_b.x = x; bus_b.y = y; bus_b.out_ready = rdy;
    end
  endtask

  task automatic sample(input bit sel, output obs_t o);
    o = '0;
    if (!sel) begin
      o.in_ready = bus_a.in_ready; o.out_valid = bus_a.out_valid; o.diff = bus_a.diff;
      o.borrow = bus_a.borrow; o.zero = bus_a.zero;
`ifdef SERIAL_SUB_OVF_EN
      o.ovf = bus_a.ovf;
`endif
    end else begin
      o.in_ready = bus_b.in_ready; o.out_valid = bus_b.out_valid; o.diff = bus_b.diff;
      o.borrow = bus_b.borrow; o.zero = bus_b.zero;
`ifdef SERIAL_SUB_OVF_EN
      o.ovf = bus_b.ovf;
`endif
    end
  endtask

  // Reference: plain modular and signed arithmetic
  task automatic model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] d,
                       output logic b, output logic z, output logic o);
    logic signed [32:0] sd;
    d  = x - y;
    b  = (x < y);
    z  = (d == 32'd0);
    sd = $signed({x[31], x}) - $signed({y[31], y});
    o  = (sd > 33'sd2147483647) || (sd < -33'sd2147483648);
  endtask

  task automatic run_op(input bit sel, input logic [31:0] x, input logic [31:0] y, input int ncyc);
    obs_t o;
    int   cyc;
    logic [31:0] ed;
    logic eb, ez, eo;
    model(x, y, ed, eb, ez, eo);
    cyc = 0;
    sample(sel, o);
    while (!o.in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++; sample(sel, o);
    end
    check("wait_in_ready", {31'd0, o.in_ready}, 32'd1);
    drive(sel, 1'b1, x, y, 1'b0);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~x, ~y, 1'b0);
    sample(sel, o);
    check("busy_in_ready", {31'd0, o.in_ready}, 32'd0);
    cyc = 0;
    while (!o.out_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++; sample(sel, o);
    end
    check("latency", cyc, ncyc);
    check("diff", o.diff, ed);
    check("borrow", {31'd0, o.borrow}, {31'd0, eb});
    check("zero", {31'd0, o.zero}, {31'd0, ez});
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", {31'd0, o.ovf}, {31'd0, eo});
`endif
    drive(sel, 1'b0, 32'd0, 32'd0, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 32'd0, 32'd0, 1'b0);
    sample(sel, o);
    check("release_out_valid", {31'd0, o.out_valid}, 32'd0);
    check("release_in_ready", {31'd0, o.in_ready}, 32'd1);
    check("idle_diff_held", o.diff, ed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t o;
    logic [31:0] xr, yr;
    int cyc;
    rst = 1'b1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], o);
      check("rst_in_ready", {31'd0, o.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, o.out_valid}, 32'd0);
      check("rst_diff", o.diff, 32'd0);
      check("rst_borrow", {31'd0, o.borrow}, 32'd0);
      check("rst_zero", {31'd0, o.zero}, 32'd0);
      check("rst_ovf", {31'd0, o.ovf}, 32'd0);
    end

    // Directed cases
    run_op(0, 32'd10, 32'd3, 32);
    run_op(0, 32'd3, 32'd10, 32);
    run_op(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32);
    run_op(0, 32'h8000_0000, 32'd1, 32);
    run_op(0, 32'd5, 32'd7, 32);
    run_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32);
    run_op(0, 32'd0, 32'hFFFF_FFFF, 32);

    // Random, with some equal-operand cases
    for (int k = 0; k < 8; k++) begin
      xr = $urandom;
      yr = (k % 3 == 0) ? xr : $urandom;
      run_op(0, xr, yr, 32);
    end

    // Result held while consumer stalls; new operands refused
    drive(0, 1'b1, 32'h100, 32'h1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc = 0;
    sample(0, o);
    while (!o.out_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++; sample(0, o);
    end
    check("stall_latency", cyc, 32);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; sample(0, o);
      check("stall_out_valid", {31'd0, o.out_valid}, 32'd1);
      check("stall_diff", o.diff, 32'h0000_00FF);
    end
    drive(0, 1'b1, 32'h55, 32'h11, 1'b0);
    @(posedge clk); #1; sample(0, o);
    check("stall_no_accept_ready", {31'd0, o.in_ready}, 32'd0);
    check("stall_no_accept_valid", {31'd0, o.out_valid}, 32'd1);
    check("stall_no_accept_diff", o.diff, 32'h0000_00FF);
    drive(0, 1'b1, 32'h55, 32'h11, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    sample(0, o);
    check("no_same_edge_accept_valid", {31'd0, o.out_valid}, 32'd0);
    check("no_same_edge_accept_ready", {31'd0, o.in_ready}, 32'd1);
    @(posedge clk); #1; sample(0, o);
    check("idle_stays_idle", {31'd0, o.in_ready}, 32'd1);

    // Abort in the middle of RUN
    drive(0, 1'b1, 32'h1234_5678, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sample(0, o);
    check("abort_out_valid", {31'd0, o.out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, o.in_ready}, 32'd1);
    check("abort_diff", o.diff, 32'd0);
    repeat (30) @(posedge clk);
    #1; sample(0, o);
    check("abort_discarded", {31'd0, o.out_valid}, 32'd0);

    // Four bits per cycle
    run_op(1, 32'd0, 32'd1, 8);
    run_op(1, 32'h8000_0000, 32'd1, 8);
    for (int k = 0; k < 4; k++) begin
      xr = $urandom;
      yr = $urandom;
      run_op(1, xr, yr, 8);
    end
    run_op(0, 32'd10, 32'd3, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
